// File: rtl/gpr_wb_queue.sv
// Write-back queue for the GPR file: two producers enqueue in order, one write per cycle drains.
// Optional macro GPR_WB_BYPASS_EN adds q_data0/q_data1 forwarding of the youngest matching entry.
module gpr_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = 10,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 10,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          hold,
  output logic          write,
  output logic [AW-1:0] inaddr,
  output logic [DW-1:0] indata,
  input  logic [AW-1:0] q_addr0,
  output logic          q_hit0,
  input  logic [AW-1:0] q_addr1,
  output logic          q_hit1,
  output logic [CW-1:0] count,
  output logic          addr_err
`ifdef GPR_WB_BYPASS_EN
  ,
  output logic [DW-1:0] q_data0,
  output logic [DW-1:0] q_data1
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_fifo_addr [DEPTH];
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_addr_err;

  logic          w_a_fire, w_b_fire, w_a_ok, w_b_ok, w_a_enq, w_b_enq, w_pop, w_empty;
  logic [PW-1:0] w_b_slot;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
    return PW'((32'(p) + n) % DEPTH);
  endfunction

  // Ready looks only at registered occupancy; B yields a slot to A when both want in.
  assign a_ready  = r_count < CW'(DEPTH);
  assign b_ready  = a_valid ? (r_count < CW'(DEPTH - 1)) : (r_count < CW'(DEPTH));

  assign w_a_fire = a_valid && a_ready;
  assign w_b_fire = b_valid && b_ready;
  assign w_a_ok   = {1'b0, a_addr} < (AW + 1)'(NREGS);
  assign w_b_ok   = {1'b0, b_addr} < (AW + 1)'(NREGS);
  assign w_a_enq  = w_a_fire && w_a_ok;
  assign w_b_enq  = w_b_fire && w_b_ok;
  assign w_b_slot = w_a_enq ? ptr_add(r_wptr, 1) : r_wptr;

  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && !hold;
  assign write    = w_pop;
  assign inaddr   = w_empty ? '0 : r_fifo_addr[r_rptr];
  assign indata   = w_empty ? '0 : r_fifo_data[r_rptr];
  assign count    = r_count;
  assign addr_err = r_addr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_wptr     <= ptr_add(r_wptr, 32'(w_a_enq) + 32'(w_b_enq));
      r_rptr     <= ptr_add(r_rptr, 32'(w_pop));
      r_count    <= r_count + CW'(w_a_enq) + CW'(w_b_enq) - CW'(w_pop);
      r_addr_err <= (w_a_fire && !w_a_ok) || (w_b_fire && !w_b_ok);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_a_enq) begin
      r_fifo_addr[r_wptr] <= a_addr;
      r_fifo_data[r_wptr] <= a_data;
    end
    if (w_b_enq) begin
      r_fifo_addr[w_b_slot] <= b_addr;
      r_fifo_data[w_b_slot] <= b_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    q_hit0 = 1'b0;
    q_hit1 = 1'b0;
`ifdef GPR_WB_BYPASS_EN
    q_data0 = '0;
    q_data1 = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (k < 32'(r_count)) begin
        if (r_fifo_addr[ptr_add(r_rptr, k)] == q_addr0) begin
          q_hit0 = 1'b1;
`ifdef GPR_WB_BYPASS_EN
          q_data0 = r_fifo_data[ptr_add(r_rptr, k)];
`endif
        end
        if (r_fifo_addr[ptr_add(r_rptr, k)] == q_addr1) begin
          q_hit1 = 1'b1;
`ifdef GPR_WB_BYPASS_EN
          q_data1 = r_fifo_data[ptr_add(r_rptr, k)];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Randomized bench for gpr_wb_queue against a queue-based reference model.
// Compile with GPR_WB_BYPASS_EN to also check the forwarded data outputs.
module tb_gpr_wb_queue;
  localparam int DEPTH = 4;
  localparam int NREGS = 10;

  typedef struct packed {
    logic [3:0] a;
    logic [9:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0, q_addr0 = '0, q_addr1 = '0;
  logic [9:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, write, q_hit0, q_hit1, addr_err;
  logic [3:0] inaddr;
  logic [9:0] indata;
  logic [2:0] count;
`ifdef GPR_WB_BYPASS_EN
  logic [9:0] q_data0, q_data1;
`endif

  gpr_wb_queue dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .hold(hold), .write(write), .inaddr(inaddr), .indata(indata),
    .q_addr0(q_addr0), .q_hit0(q_hit0), .q_addr1(q_addr1), .q_hit1(q_hit1),
    .count(count), .addr_err(addr_err)
`ifdef GPR_WB_BYPASS_EN
    , .q_data0(q_data0), .q_data1(q_data1)
`endif
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  ent_t mq[$];
  logic exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic step(input logic av, input logic [3:0] aa, input logic [9:0] ad,
                      input logic bv, input logic [3:0] ba, input logic [9:0] bd,
                      input logic hd, input logic [3:0] qa0, input logic [3:0] qa1,
                      output logic a_acc, output logic b_acc);
    int   n;
    logic e_ar, e_br, h0, h1;
    logic [9:0] d0, d1;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    hold = hd; q_addr0 = qa0; q_addr1 = qa1;
    #1;
    n    = mq.size();
    e_ar = (n <= DEPTH - 1);
    e_br = av ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
    h0 = 1'b0; h1 = 1'b0; d0 = '0; d1 = '0;
    foreach (mq[i]) begin
      if (mq[i].a == qa0) begin h0 = 1'b1; d0 = mq[i].d; end
      if (mq[i].a == qa1) begin h1 = 1'b1; d1 = mq[i].d; end
    end
    check_eq("a_ready", 32'(a_ready), 32'(e_ar));
    check_eq("b_ready", 32'(b_ready), 32'(e_br));
    check_eq("count", 32'(count), 32'(n));
    check_eq("write", 32'(write), 32'(n > 0 && !hd));
    check_eq("inaddr", 32'(inaddr), (n > 0) ? 32'(mq[0].a) : 32'd0);
    check_eq("indata", 32'(indata), (n > 0) ? 32'(mq[0].d) : 32'd0);
    check_eq("addr_err", 32'(addr_err), 32'(exp_err));
    check_eq("q_hit0", 32'(q_hit0), 32'(h0));
    check_eq("q_hit1", 32'(q_hit1), 32'(h1));
`ifdef GPR_WB_BYPASS_EN
    check_eq("q_data0", 32'(q_data0), 32'(d0));
    check_eq("q_data1", 32'(q_data1), 32'(d1));
`endif
    @(posedge clk);
    a_acc = av && e_ar;
    b_acc = bv && e_br;
    if (n > 0 && !hd) void'(mq.pop_front());
    exp_err = 1'b0;
    if (a_acc) begin
      if (aa < NREGS) mq.push_back('{a: aa, d: ad}); else exp_err = 1'b1;
    end
    if (b_acc) begin
      if (ba < NREGS) mq.push_back('{a: ba, d: bd}); else exp_err = 1'b1;
    end
  endtask

  task automatic idle(input logic hd, input logic [3:0] qa0);
    logic x, y;
    step(1'b0, 4'd0, 10'd0, 1'b0, 4'd0, 10'd0, hd, qa0, 4'd0, x, y);
  endtask

  initial begin
    logic       aa, ba, a_pend, b_pend, hd;
    logic [3:0] pa, pb;
    logic [9:0] pda, pdb;

    // Outputs while held in reset
    #12;
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_indata", 32'(indata), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single write: appears one cycle after acceptance
    step(1'b1, 4'd3, 10'h155, 1'b0, 4'd0, 10'd0, 1'b0, 4'd3, 4'd0, aa, ba);
    #1;
    check_eq("single_write", 32'(write), 32'd1);
    check_eq("single_addr", 32'(inaddr), 32'd3);
    check_eq("single_data", 32'(indata), 32'h155);
    idle(1'b0, 4'd3);
    idle(1'b0, 4'd3);

    // Same-cycle A and B to one register: A then B, lookup stays hit
    step(1'b1, 4'd2, 10'h011, 1'b1, 4'd2, 10'h022, 1'b0, 4'd2, 4'd2, aa, ba);
    idle(1'b0, 4'd2);
    idle(1'b0, 4'd2);
    idle(1'b0, 4'd2);

    // Fill under hold, then drain
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'(i), 10'(i * 7 + 1), 1'b1, 4'd9, 10'h3ff, 1'b1, 4'(i), 4'd9, aa, ba);
    for (int i = 0; i < 6; i++) idle(1'b0, 4'd1);

    // Out-of-range A alongside a good B
    step(1'b1, 4'd12, 10'h0aa, 1'b1, 4'd5, 10'h0bb, 1'b0, 4'd12, 4'd5, aa, ba);
    idle(1'b0, 4'd5);
    idle(1'b0, 4'd5);

    // Reset in the middle of a cycle with three entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'(i + 4), 10'(i + 100), 1'b0, 4'd0, 10'd0, 1'b1, 4'd4, 4'd5, aa, ba);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_write", 32'(write), 32'd0);
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_hit", 32'(q_hit0), 32'd0);
    mq.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0, 4'd4);

    // Randomized traffic; producers keep a refused request stable
    a_pend = 1'b0; b_pend = 1'b0;
    pa = '0; pb = '0; pda = '0; pdb = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!a_pend) begin
        a_pend = ($urandom_range(0, 9) < 6);
        pa = 4'($urandom_range(0, 11)); pda = 10'($urandom);
      end
      if (!b_pend) begin
        b_pend = ($urandom_range(0, 9) < 5);
        pb = 4'($urandom_range(0, 11)); pdb = 10'($urandom);
      end
      hd = ((cyc / 40) % 3 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      step(a_pend, pa, pda, b_pend, pb, pdb, hd,
           4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), aa, ba);
      if (aa) a_pend = 1'b0;
      if (ba) b_pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_wb_queue.md
Name: gpr_wb_queue

Overview:
- Write-back queue sitting in front of the 10-entry, 10-bit general-purpose register file.
- Collects register write requests from two producers (A = ALU, B = memory/load) through valid/ready handshakes.
- Buffers requests in a small in-order FIFO and drives the register file's single write port at one write per cycle.
- Exposes two hazard-lookup ports so operand readers can detect registers that still have a pending write.

Parameters:
- DEPTH, 4, FIFO entries (≥2).
- NREGS, 10, number of valid register addresses (0..NREGS-1).
- AW, 4, register address width.
- DW, 10, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- a_valid  in  1  producer A request.
- a_ready  out  1  queue can take A this cycle.
- a_addr  in  AW  destination register for A.
- a_data  in  DW  write data for A.
- b_valid  in  1  producer B request.
- b_ready  out  1  queue can take B this cycle.
- b_addr  in  AW  destination register for B.
- b_data  in  DW  write data for B.
- hold  in  1  stall draining (register file busy/debug freeze).
- write  out  1  register-file write strobe.
- inaddr  out  AW  register-file write address.
- indata  out  DW  register-file write data.
- q_addr0  in  AW  lookup port 0 address.
- q_hit0  out  1  pending write to q_addr0 exists.
- q_addr1  in  AW  lookup port 1 address.
- q_hit1  out  1  pending write to q_addr1 exists.
- count  out  $clog2(DEPTH+1)  current occupancy.
- addr_err  out  1  one-cycle pulse: an out-of-range address was dropped.

Behaviour:
- **Reset** (rst low, async): FIFO flushed, count=0, addr_err=0, write=0, inaddr=0, indata=0, q_hit*=0. Reset mid-operation discards all pending entries; nothing is written.
- **Ready:** from registered count only, so there is no pass-through when full.
  - a_ready = (count ≤ DEPTH-1).
  - b_ready = a_valid ? (count ≤ DEPTH-2) : (count ≤ DEPTH-1).
- **Handshake:** transfer on a rising edge when valid&&ready. Producers hold addr/data stable while valid && !ready.
- **Ordering:** when A and B transfer in the same cycle, A is enqueued ahead of B. FIFO is strictly in order; no coalescing of same-address entries.
- **Out-of-range address** (addr ≥ NREGS): handshake completes but nothing is enqueued. addr_err=1 for the following cycle; two bad requests in one cycle still give a single pulse.
- **Drain:** write = !empty && !hold; inaddr/indata = head entry, 0 when empty. Head pops on the edge where write=1. Enqueue and dequeue in the same cycle are allowed; count tracks the net change.
- **Latency:** request accepted at edge N appears on write no earlier than cycle N+1 (empty queue, hold=0).
- **Throughput:** one write per cycle. Sustained two-producer input backpressures B first.
- **Lookup** (combinational): q_hitX=1 if any valid FIFO entry (including the head being written this cycle) has addr==q_addrX. Requests being accepted in the current cycle are not visible until the next cycle.
- **hold:** freezes draining only; enqueue continues until full.

Optional Feature:
- Macro: GPR_WB_BYPASS_EN.
- Defined:
  - Adds outputs q_data0/q_data1 (DW).
  - Each returns the data of the youngest matching entry, 0 when there is no hit, so readers can forward pending values instead of stalling.
- Undefined:
  - Ports absent; hit-only lookup.

Test Plan:
- **Single write:** reset, A writes addr 3 data 0x155, hold=0 → next cycle write=1, inaddr=3, indata=0x155, count returns to 0.
- **Simultaneous producers:** A(2,0x011) and B(2,0x022) in the same cycle, empty queue → writes 0x011 then 0x022 to reg 2 on consecutive cycles. q_hit0 for addr 2 stays 1 for both cycles; with GPR_WB_BYPASS_EN, q_data0=0x022 in cycle 1.
- **Backpressure and hold:** hold=1, DEPTH=4, A streams 4 requests → a_ready=0 at count=4 and b_ready=0. Release hold → 4 writes in order; a_ready rises once count drops to 3.
- **Out-of-range address:** A addr 12 → accepted, no enqueue, addr_err pulses 1 cycle, no write. Same cycle B addr 5 is enqueued normally.
- **Reset mid-operation:** 3 entries pending, assert rst between edges → write=0 and count=0 immediately. After release, no stale writes appear.
- **Full queue with drain:** count=DEPTH, hold=0 → one pop; a_ready next cycle=1, b_ready=1 only while a_valid=0.
